// File: rtl/adc_scan_scheduler_pkg.sv
// adc_scan_scheduler_pkg: shared sizes, FSM encoding and a lowest-channel helper
// for the ADC scan scheduler.
package adc_scan_scheduler_pkg;

    localparam int CH_NUM = 8;
    localparam int ADC_W  = 12;
    localparam int ADDR_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        STORE,
        GAP
    } state_e;

    function automatic logic [ADDR_W-1:0] first_ch(input logic [CH_NUM-1:0] mask);
        first_ch = '0;
        for (int i = CH_NUM - 1; i >= 0; i--)
            if (mask[i]) first_ch = ADDR_W'(i);
    endfunction

endpackage

// File: rtl/adc_scan_scheduler_next_channel_sel.sv
// adc_scan_scheduler_next_channel_sel: finds the next higher enabled channel
// above cur_i and flags when no enabled channel remains in the scan.
module adc_scan_scheduler_next_channel_sel
    import adc_scan_scheduler_pkg::*;
(
    input  logic [CH_NUM-1:0] mask_i,
    input  logic [ADDR_W-1:0] cur_i,
    output logic [ADDR_W-1:0] next_o,
    output logic              none_left_o
);

    always_comb begin
        next_o      = '0;
        none_left_o = 1'b1;
        for (int i = CH_NUM - 1; i >= 0; i--)
            if (mask_i[i] && ADDR_W'(i) > cur_i) begin
                next_o      = ADDR_W'(i);
                none_left_o = 1'b0;
            end
    end

endmodule

// File: rtl/adc_scan_scheduler.sv
// adc_scan_scheduler: scans the enabled ADC channels in ascending order, stores
// each conversion in a register table and flags BUSY handshake timeouts.
module adc_scan_scheduler
    import adc_scan_scheduler_pkg::*;
#(
    parameter int SCAN_GAP     = 1000,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [CH_NUM-1:0] ch_mask,
    output logic              adc_start,
    output logic [ADDR_W-1:0] adc_addr,
    input  logic              adc_busy,
    input  logic [ADC_W-1:0]  adc_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ADC_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic              scan_done,
    output logic              timeout_err
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 2);
    localparam int GW = $clog2(SCAN_GAP + 2);

    state_e            state_q, state_d, adv_state;
    logic [ADDR_W-1:0] addr_q, addr_d, next_ch;
    logic [CH_NUM-1:0] mask_q, mask_d, valid_q;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [ADC_W-1:0]  data_q, data_d;
    logic [ADC_W-1:0]  res_q [CH_NUM];
    logic              done_q, done_d, err_q, err_d;
    logic              none_left, tmo_hit, gap_hit, timed_out, advance, launch;

    adc_scan_scheduler_next_channel_sel u_next (
        .mask_i     (mask_q),
        .cur_i      (addr_q),
        .next_o     (next_ch),
        .none_left_o(none_left)
    );

    assign tmo_hit   = int'(tmo_q) + 1 >= BUSY_TIMEOUT;
    assign gap_hit   = int'(gap_q) + 1 >= SCAN_GAP;
    assign timed_out = state_q == WAIT_BUSY && !adc_busy && tmo_hit;
    assign advance   = timed_out || state_q == STORE;
    assign launch    = state_q == IDLE && run && ch_mask != '0;
    // Dropping run ends the scan quietly once the in-flight channel retires.
    assign adv_state = !run ? IDLE : (none_left ? GAP : ISSUE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = launch ? ISSUE : IDLE;
            ISSUE:     state_d = WAIT_BUSY;
            WAIT_BUSY: state_d = adc_busy ? WAIT_DONE : (tmo_hit ? adv_state : WAIT_BUSY);
            WAIT_DONE: state_d = adc_busy ? WAIT_DONE : STORE;
            STORE:     state_d = adv_state;
            GAP:       state_d = gap_hit ? IDLE : GAP;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        mask_d = launch ? ch_mask : mask_q;
        addr_d = launch ? first_ch(ch_mask) : (advance && run && !none_left) ? next_ch : addr_q;
        tmo_d  = state_q == WAIT_BUSY ? tmo_q + 1'b1 : '0;
        gap_d  = state_q == GAP ? gap_q + 1'b1 : '0;
        data_d = (state_q == WAIT_DONE && !adc_busy) ? adc_data : data_q;
        done_d = advance && run && none_left;
        err_d  = err_q || timed_out;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            mask_q  <= '0;
            tmo_q   <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            valid_q <= '0;
            for (int i = 0; i < CH_NUM; i++) res_q[i] <= '0;
        end else begin
            addr_q <= addr_d;
            mask_q <= mask_d;
            tmo_q  <= tmo_d;
            gap_q  <= gap_d;
            data_q <= data_d;
            done_q <= done_d;
            err_q  <= err_d;
            if (state_q == STORE) begin
                res_q[addr_q]   <= data_q;
                valid_q[addr_q] <= 1'b1;
            end
        end
    end

    always_comb begin
        adc_start   = state_q == ISSUE;
        adc_addr    = addr_q;
        scan_done   = done_q;
        timeout_err = err_q;
        rd_data     = res_q[rd_addr];
        rd_valid    = valid_q[rd_addr];
    end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// tb_adc_scan_scheduler: randomized ADC responder plus a transaction-level model
// of scan order, completion timing and the result table.
module tb_adc_scan_scheduler;

    localparam int GAP = 4;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        adc_busy = 1'b0;
    logic [7:0]  ch_mask = '0;
    logic [11:0] adc_data = '0;
    logic [2:0]  rd_addr = '0;
    logic [2:0]  adc_addr;
    logic        adc_start, scan_done, timeout_err, rd_valid;
    logic [11:0] rd_data;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int tmo_mode = 2;
    int hold = 0;
    bit fixed = 1'b1;

    int r_rise = -1, r_fall = -1;
    bit r_tmo = 1'b0;
    logic [11:0] r_data = '0;

    logic [11:0] m_res [8];
    bit          m_val [8];
    bit          m_err = 1'b0;
    int          q[$];
    int          next_start = -1, idle_from = -1, done_at = -1;
    bit          conv_on = 1'b0, conv_tmo = 1'b0;
    int          conv_addr = 0, conv_c = -1;
    logic [11:0] conv_data = '0;

    int start_addr[$], start_cyc[$], done_cyc[$];

    adc_scan_scheduler #(.SCAN_GAP(GAP), .BUSY_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .ch_mask    (ch_mask),
        .adc_start  (adc_start),
        .adc_addr   (adc_addr),
        .adc_busy   (adc_busy),
        .adc_data   (adc_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .scan_done  (scan_done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Inputs visible at a falling edge are the ones the preceding rising edge consumed.
    always @(negedge clk) begin
        int  t, a;
        bit  exp_start;
        t = cyc;
        if (!rst) begin
            chk("rst_start", adc_start, 0);
            chk("rst_addr", adc_addr, 0);
            chk("rst_done", scan_done, 0);
            chk("rst_err", timeout_err, 0);
            chk("rst_valid", rd_valid, 0);
            chk("rst_data", rd_data, 0);
            foreach (m_res[i]) begin
                m_res[i] = '0;
                m_val[i] = 1'b0;
            end
            m_err = 1'b0;
            q.delete();
            next_start = -1;
            done_at = -1;
            conv_on = 1'b0;
            idle_from = t;
        end else begin
            if (conv_on && t == conv_c) begin
                conv_on = 1'b0;
                if (conv_tmo) m_err = 1'b1;
                else begin
                    m_res[conv_addr] = conv_data;
                    m_val[conv_addr] = 1'b1;
                end
                if (!run) begin
                    q.delete();
                    idle_from = t;
                end else if (q.size() == 0) begin
                    done_at = t;
                    idle_from = t + (GAP > 0 ? GAP : 1);
                end else next_start = t;
            end
            exp_start = next_start == t || (idle_from >= 0 && t - 1 >= idle_from && run && ch_mask != 0);
            if (exp_start && next_start != t) begin
                q.delete();
                for (int i = 0; i < 8; i++)
                    if (ch_mask[i]) q.push_back(i);
                idle_from = -1;
            end
            if (adc_start) begin
                r_tmo  = tmo_mode == 1 || (tmo_mode == 0 && $urandom_range(5) == 0);
                r_rise = r_tmo ? -1 : t + int'($urandom_range(1, TMO));
                r_fall = r_rise + (hold > 0 ? hold : int'($urandom_range(1, 4)));
                r_data = fixed ? (12'(adc_addr) + 12'd1) * 12'h111 : 12'($urandom);
                start_addr.push_back(int'(adc_addr));
                start_cyc.push_back(t);
            end
            chk("start", adc_start, exp_start);
            if (exp_start) begin
                a = q.pop_front();
                chk("start_addr", adc_addr, a);
                conv_on    = 1'b1;
                conv_addr  = a;
                conv_tmo   = r_tmo;
                conv_c     = r_tmo ? t + TMO + 1 : r_fall + 2;
                conv_data  = r_data;
                next_start = -1;
            end else if (conv_on) chk("addr_hold", adc_addr, conv_addr);
            chk("scan_done", scan_done, done_at == t);
            if (scan_done) done_cyc.push_back(t);
            chk("timeout_err", timeout_err, m_err);
            chk("rd_valid", rd_valid, m_val[rd_addr]);
            chk("rd_data", rd_data, m_res[rd_addr]);
        end
        adc_busy = r_rise >= 0 && t >= r_rise && t < r_fall;
        if (r_rise >= 0 && t == r_fall) adc_data = r_data;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            rd_addr = 3'($urandom);
        end
    endtask

    task automatic clear_logs();
        start_addr.delete();
        start_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic wait_starts(input int n, input int budget);
        int k = 0;
        while (start_addr.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        chk("wait_starts", start_addr.size() >= n, 1);
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (done_cyc.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        chk("wait_done", done_cyc.size() >= n, 1);
    endtask

    task automatic rd_chk(input logic [2:0] a, input bit v, input logic [11:0] d, input bit cd);
        @(negedge clk);
        #1;
        rd_addr = a;
        #1;
        chk("lit_valid", rd_valid, v);
        if (cd) chk("lit_data", rd_data, d);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(2);
    endtask

    initial begin
        int k;
        tick(4);
        rst = 1'b1;
        tick(2);

        // Two-channel scan with fixed conversion data.
        clear_logs();
        ch_mask = 8'h05;
        run = 1'b1;
        wait_done(1, 200);
        run = 1'b0;
        tick(10);
        chk("s1_nstarts", start_addr.size(), 2);
        chk("s1_first", start_addr[0], 0);
        chk("s1_second", start_addr[1], 2);
        chk("s1_ndone", done_cyc.size(), 1);
        rd_chk(3'd0, 1'b1, 12'h111, 1'b1);
        rd_chk(3'd2, 1'b1, 12'h333, 1'b1);
        rd_chk(3'd1, 1'b0, 12'h000, 1'b1);

        // BUSY never rises.
        clear_logs();
        tmo_mode = 1;
        ch_mask = 8'h02;
        run = 1'b1;
        wait_done(1, 100);
        run = 1'b0;
        tick(2);
        chk("s2_err", timeout_err, 1);
        chk("s2_latency", done_cyc[0] - start_cyc[0], TMO + 1);
        chk("s2_nstarts", start_addr.size(), 1);
        rd_chk(3'd1, 1'b0, 12'h000, 1'b1);
        do_reset();

        // Full mask scan and gap timing into the next scan.
        clear_logs();
        tmo_mode = 2;
        fixed = 1'b0;
        ch_mask = 8'hFF;
        run = 1'b1;
        wait_starts(9, 400);
        run = 1'b0;
        for (int i = 0; i < 8; i++) chk("s3_order", start_addr[i], i);
        chk("s3_wrap", start_addr[8], 0);
        chk("s3_ndone", done_cyc.size(), 1);
        chk("s3_gap", start_cyc[8] - done_cyc[0], GAP + 1);
        tick(40);

        // Mask change mid-scan applies to the following scan.
        clear_logs();
        ch_mask = 8'h01;
        run = 1'b1;
        wait_starts(1, 20);
        ch_mask = 8'h80;
        wait_done(2, 200);
        chk("s4_nstarts", start_addr.size(), 2);
        chk("s4_first", start_addr[0], 0);
        chk("s4_second", start_addr[1], 7);
        run = 1'b0;
        tick(40);
        do_reset();

        // run dropped during channel 3.
        clear_logs();
        ch_mask = 8'hFF;
        run = 1'b1;
        wait_starts(4, 200);
        run = 1'b0;
        tick(60);
        chk("s5_nstarts", start_addr.size(), 4);
        chk("s5_last", start_addr[3], 3);
        chk("s5_ndone", done_cyc.size(), 0);
        rd_chk(3'd3, 1'b1, 12'h000, 1'b0);
        rd_chk(3'd4, 1'b0, 12'h000, 1'b1);

        // Reset while waiting for BUSY to fall; the late fall must be ignored.
        clear_logs();
        hold = 10;
        ch_mask = 8'h01;
        run = 1'b1;
        wait_starts(1, 20);
        k = 0;
        while (!adc_busy && k < 20) begin
            tick(1);
            k++;
        end
        chk("s6_busy", adc_busy, 1);
        tick(1);
        rd_addr = 3'd0;
        rst = 1'b0;
        run = 1'b0;
        #1;
        chk("s6_start", adc_start, 0);
        chk("s6_addr", adc_addr, 0);
        chk("s6_valid", rd_valid, 0);
        tick(2);
        rst = 1'b1;
        tick(20);
        hold = 0;
        chk("s6_nstarts", start_addr.size(), 1);
        rd_chk(3'd0, 1'b0, 12'h000, 1'b1);
        do_reset();

        // Randomized run/mask traffic with occasional timeouts.
        tmo_mode = 0;
        ch_mask = 8'($urandom);
        run = 1'b1;
        repeat (3000) begin
            tick(1);
            if ($urandom_range(15) == 0) ch_mask = $urandom_range(7) == 0 ? 8'h00 : 8'($urandom);
            if ($urandom_range(150) == 0) run = ~run;
        end
        run = 1'b0;
        tick(60);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adc_scan_scheduler.md
ADC_SCAN_SCHEDULER -- requirements
Module: adc_scan_scheduler

Interface
REQ-001 Parameter SCAN_GAP, default 1000, idle clk cycles between completed scans.
REQ-002 Parameter BUSY_TIMEOUT, default 16, max clk cycles from START to BUSY high.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 run  input  1  level; 1 = scanning permitted.
REQ-006 ch_mask  input  8  channel enable, bit n = channel n.
REQ-007 adc_start  output  1  START to ADC interface, one-cycle pulse.
REQ-008 adc_addr  output  3  ADDR to ADC interface; held stable from adc_start until capture.
REQ-009 adc_busy  input  1  BUSY from ADC interface.
REQ-010 adc_data  input  12  DATA from ADC interface; valid when adc_busy falls.
REQ-011 rd_addr  input  3  result read select.
REQ-012 rd_data  output  12  stored result of channel rd_addr, combinational read.
REQ-013 rd_valid  output  1  channel rd_addr has held a result since reset.
REQ-014 scan_done  output  1  one-cycle pulse after the last enabled channel of a scan is stored.
REQ-015 timeout_err  output  1  sticky; set on a BUSY timeout, cleared only by reset.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, STORE, GAP.
REQ-017 IDLE: when run=1 and ch_mask!=0, select lowest enabled channel, go ISSUE; else stay IDLE.
REQ-018 ISSUE: adc_start=1 for exactly one cycle, timeout counter cleared, go WAIT_BUSY.
REQ-019 WAIT_BUSY: on adc_busy=1 go WAIT_DONE; after BUSY_TIMEOUT cycles without it set timeout_err, advance channel without storing.
REQ-020 WAIT_DONE: on adc_busy=0 go STORE; no timeout in this state.
REQ-021 STORE: write adc_data into result[adc_addr], set valid[adc_addr], then advance channel.
REQ-022 Advance: next higher enabled channel from ch_mask sampled at scan start; if none remain, pulse scan_done and go GAP.
REQ-023 GAP: count SCAN_GAP cycles then go IDLE; SCAN_GAP=0 goes IDLE next cycle.
REQ-024 ch_mask sampled into an internal register on IDLE->ISSUE; changes mid-scan take effect next scan.
REQ-025 run=0 mid-scan: current conversion completes and is stored, then FSM goes IDLE without scan_done.
REQ-026 Timed-out channel still counts toward scan completion; scan_done pulses normally.
REQ-027 adc_start never asserted while FSM is in WAIT_BUSY, WAIT_DONE or STORE.
REQ-028 Read port and STORE on the same channel in the same cycle: rd_data shows old value, new value next cycle.
REQ-029 Latency adc_busy fall -> result readable: 2 clk cycles.

Reset
REQ-030 On rst=0: FSM IDLE, adc_start=0, adc_addr=0, scan_done=0, timeout_err=0, all valid bits 0, results 12'h000, counters 0.
REQ-031 Reset mid-conversion aborts immediately; late adc_busy/adc_data after reset are ignored until the next ISSUE.

Structure
REQ-032 Shared package holds FSM state encoding, CH_NUM=8, ADC_W=12, ADDR_W=3.
REQ-033 One sub-module next_channel_sel: combinational, given mask and current channel returns next higher enabled channel and a none-left flag.
REQ-034 Result storage is a register array, not block RAM.

Verification
REQ-035 Mask 8'b0000_0101, run=1, model returns 12'h111/12'h333 for ch0/ch2 -> ISSUE order ch0, ch2; rd_data(0)=111, rd_data(2)=333; one scan_done; valid only on ch0, ch2.
REQ-036 Model never raises BUSY on ch1, mask 8'h02 -> timeout_err=1 after 16 cycles, result[1] unchanged, scan_done pulses.
REQ-037 Mask 8'hFF, SCAN_GAP=4 -> 8 conversions ch0..ch7, scan_done, exactly 4 gap cycles, next adc_start at ch0.
REQ-038 Mask changed 8'h01->8'h80 during ch0 conversion -> current scan ends after ch0; next scan converts only ch7.
REQ-039 run dropped during ch3 of 8'hFF scan -> ch3 stored, no ch4 start, no scan_done, FSM IDLE.
REQ-040 rst asserted in WAIT_DONE -> all outputs at reset values same cycle; later adc_busy fall writes nothing.
